// File: rtl/oled_display_arbiter_pkg.sv
// Shared definitions for the OLED display arbiter slice: FSM states,
// page geometry and a constant-width helper.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_FIN,
    WAIT_REL,
    HOLD
  } state_e;

  localparam int unsigned PAGE_W  = 128;
  localparam int unsigned PAGES   = 4;
  localparam int unsigned FRAME_W = PAGE_W * PAGES;
  localparam int unsigned ID_W    = 3;

  // Number of bits needed to index 'value' distinct items.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned v;
    int unsigned     r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oled_display_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_id, with wrap.
module rr_arbiter
  import oled_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  logic [ID_W:0] cand;

  // Scan offsets 1..NUM_REQ from last_id; the first pending requester wins.
  always_comb begin
    valid = 1'b0;
    id    = last_id;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_id} + (ID_W + 1)'(off);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (cand == (ID_W + 1)'(i))) begin
          valid = 1'b1;
          id    = cand[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/oled_display_arbiter.sv
// Shares one PmodOLED controller among NUM_REQ requesters: round-robin grant,
// EN/FIN four-phase handshake with timeout, then a minimum on-screen hold.
module oled_display_arbiter
  import oled_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*FRAME_W-1:0]   req_pages,
  output logic [NUM_REQ-1:0]           ack,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic                         oled_en,
  output logic [PAGE_W-1:0]            oled_page0,
  output logic [PAGE_W-1:0]            oled_page1,
  output logic [PAGE_W-1:0]            oled_page2,
  output logic [PAGE_W-1:0]            oled_page3,
  input  logic                         oled_fin,
  output logic                         timeout_err
);

  localparam longint unsigned TMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned     TW   = clog2(TMAX + 1);
  localparam logic [TW-1:0]   HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]   TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] LAST_ID_RST = ID_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 en_q, en_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic                 arb_valid;
  logic [ID_W-1:0]      arb_id;
  logic [FRAME_W-1:0]   sel_frame;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [TW-1:0]        timer_inc;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (req),
    .last_id (grant_q),
    .valid   (arb_valid),
    .id      (arb_id)
  );

  // Frame slice and ack mask of the current grant, built with constant selects.
  always_comb begin
    sel_frame    = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_frame       = req_pages[i*FRAME_W +: FRAME_W];
        grant_onehot[i] = 1'b1;
      end
    end
    timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
  end

  // Next-state and next-output logic of the grant/handshake/hold sequence.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    frame_d = frame_q;
    en_d    = en_q;
    ack_d   = '0;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        frame_d = sel_frame;
        en_d    = 1'b1;
        timer_d = '0;
        state_d = WAIT_FIN;
      end
      WAIT_FIN: begin
        en_d = 1'b1;
        if (oled_fin) begin
          ack_d   = grant_onehot;
          en_d    = 1'b0;
          timer_d = '0;
          state_d = WAIT_REL;
        end else if (timer_q >= TO_LAST) begin
          err_d   = 1'b1;
          en_d    = 1'b0;
          timer_d = '0;
          state_d = WAIT_REL;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_REL: begin
        en_d = 1'b0;
        if (!oled_fin) begin
          timer_d = '0;
          state_d = HOLD;
        end else if (timer_q >= TO_LAST) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end else begin
          timer_d = timer_inc;
        end
      end
      HOLD: begin
        if (timer_q >= HOLD_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= LAST_ID_RST;
      frame_q <= '0;
      en_q    <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      frame_q <= frame_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign ack         = ack_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign oled_en     = en_q;
  assign timeout_err = err_q;
  assign oled_page0  = frame_q[0*PAGE_W +: PAGE_W];
  assign oled_page1  = frame_q[1*PAGE_W +: PAGE_W];
  assign oled_page2  = frame_q[2*PAGE_W +: PAGE_W];
  assign oled_page3  = frame_q[3*PAGE_W +: PAGE_W];

endmodule

// File: tb/tb_oled_display_arbiter.sv
// Directed bench for oled_display_arbiter with a behavioural OLED controller
// and a scoreboard of expected grants (id + frame) popped on each ack.
module tb_oled_display_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int TO   = 20;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*512-1:0] req_pages = '0;
  logic [N-1:0]     ack;
  logic [2:0]       grant_id;
  logic             busy;
  logic             oled_en;
  logic [127:0]     oled_page0, oled_page1, oled_page2, oled_page3;
  logic             oled_fin = 1'b0;
  logic             timeout_err;

  bit fin_never = 1'b0;
  int fin_cnt   = 0;

  oled_display_arbiter #(
    .NUM_REQ        (N),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req         (req),
    .req_pages   (req_pages),
    .ack         (ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .oled_en     (oled_en),
    .oled_page0  (oled_page0),
    .oled_page1  (oled_page1),
    .oled_page2  (oled_page2),
    .oled_page3  (oled_page3),
    .oled_fin    (oled_fin),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  // OLED controller model: FIN rises 10 cycles after EN rises, falls 1 cycle after EN falls.
  always @(posedge CLK) begin
    if (RST) begin
      oled_fin <= 1'b0;
      fin_cnt  <= 0;
    end else if (oled_en) begin
      fin_cnt <= fin_cnt + 1;
      if (fin_cnt == 9 && !fin_never) oled_fin <= 1'b1;
    end else begin
      fin_cnt  <= 0;
      oled_fin <= 1'b0;
    end
  end

  typedef struct {
    int           id;
    logic [511:0] frame;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   pend[N];
  bit   prev_en = 0, prev_busy = 0, gap_valid = 0;
  int   prev_ack = 0;
  int   en_run = 0, last_en_run = 0, en_low_run = 0, en_fall_cnt = 0;
  int   en_rise_cyc = 0, ack_cyc = 0, busy_fall_cyc = 0, ack_cnt = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_frame(input int seed);
    logic [511:0] f;
    for (int w = 0; w < 16; w++)
      f[w*32 +: 32] = (32'(seed) * 32'h9E37_79B9) ^ (32'(w) * 32'h0101_0101 + 32'h5A5A_0000);
    return f;
  endfunction

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < N; i++) if (pend[i] > 0) r = 1;
    return r;
  endfunction

  task automatic push(input int id, input logic [511:0] frame);
    exp_t e;
    e.id = id;
    e.frame = frame;
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic [511:0] pages;
    pages = {oled_page3, oled_page2, oled_page1, oled_page0};
    if (oled_en && !prev_en) begin
      en_rise_cyc = cycle;
      chki("sb_nonempty_on_grant", int'(sb.size() != 0), 1);
      if (sb.size() != 0) chki("grant_id", int'(grant_id), sb[0].id);
      if (gap_valid) chki("idle_gap_ge_hold", int'(en_low_run >= HOLD), 1);
    end
    if (oled_en) begin
      en_run++;
      if (sb.size() != 0) chk("pages_stable", pages, sb[0].frame);
    end else begin
      if (prev_en) begin
        en_fall_cnt++;
        last_en_run = en_run;
        en_low_run  = 0;
        gap_valid   = 1;
      end
      en_run = 0;
      en_low_run++;
    end
    if (ack != '0) begin
      ack_cnt++;
      ack_cyc = cycle;
      chki("ack_single_cycle", prev_ack, 0);
      chki("sb_nonempty_on_ack", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        chki("ack_onehot", int'(ack), 1 << sb[0].id);
        void'(sb.pop_front());
      end
    end
    if (prev_busy && !busy) busy_fall_cyc = cycle;
    prev_en   = oled_en;
    prev_busy = busy;
    prev_ack  = int'(ack);
  endtask

  task automatic step();
    @(negedge CLK);
    cycle++;
    monitor();
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) req[i] = (pend[i] > 0);
  endtask

  // One cycle of requester behaviour: drop req after its ack, re-raise if more frames remain.
  task automatic tick();
    step();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        pend[i]--;
        req[i] = 1'b0;
      end else begin
        req[i] = (pend[i] > 0);
      end
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int left = budget;
    drive_req();
    do begin
      tick();
      left--;
    end while ((any_pend() || busy) && left > 0);
    chki(tag, int'(!any_pend() && !busy), 1);
  endtask

  task automatic reset_checks(input string tag);
    chki({tag, "_en"}, int'(oled_en), 0);
    chki({tag, "_ack"}, int'(ack), 0);
    chki({tag, "_busy"}, int'(busy), 0);
    chki({tag, "_grant_id"}, int'(grant_id), N - 1);
    chk({tag, "_pages"}, {oled_page3, oled_page2, oled_page1, oled_page0}, '0);
    chki({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    logic [511:0] f0, f1, f2, g0;
    int start, acks0, falls0, left;
    bit mutated;

    f0 = mk_frame(1);
    f1 = mk_frame(2);
    f2 = mk_frame(3);
    g0 = mk_frame(7);
    for (int i = 0; i < N; i++) pend[i] = 0;
    req_pages = {f2, f1, f0};

    // Reset
    RST = 1'b1;
    repeat (3) step();
    reset_checks("rst");
    RST = 1'b0;

    // All three request together: served 0, 1, 2
    push(0, f0); push(1, f1); push(2, f2);
    pend[0] = 1; pend[1] = 1; pend[2] = 1;
    acks0 = ack_cnt;
    run_until_idle("t2_done", 400);
    chki("t2_acks", ack_cnt - acks0, 3);
    chki("t2_sb_empty", sb.size(), 0);

    // Fairness: 0 and 2 keep requesting, expect 0, 2, 0, 2
    push(0, f0); push(2, f2); push(0, f0); push(2, f2);
    pend[0] = 2; pend[2] = 2;
    run_until_idle("t3_done", 500);
    chki("t3_sb_empty", sb.size(), 0);

    // Single request from requester 1: latency, ack, busy release
    push(1, f1);
    pend[1] = 1;
    start = cycle;
    run_until_idle("t1_done", 200);
    chki("t1_en_latency", en_rise_cyc - start, 2);
    chki("t1_busy_after_ack", busy_fall_cyc - ack_cyc, HOLD + 2);
    chki("t1_sb_empty", sb.size(), 0);

    // Requester 0 rewrites its pages while EN is high; buses keep the latched frame
    push(0, f0); push(0, g0);
    pend[0] = 2;
    mutated = 0;
    left = 400;
    drive_req();
    do begin
      tick();
      left--;
      if (oled_en && !mutated) begin
        req_pages[0 +: 512] = g0;
        mutated = 1;
      end
    end while ((any_pend() || busy) && left > 0);
    chki("t6_done", int'(!any_pend() && !busy), 1);
    chki("t6_mutated", int'(mutated), 1);
    chki("t6_sb_empty", sb.size(), 0);

    // FIN never rises: timeout, no ack, re-grant after HOLD
    push(2, f2);
    pend[2] = 1;
    fin_never = 1'b1;
    acks0 = ack_cnt;
    falls0 = en_fall_cnt;
    left = 200;
    drive_req();
    do begin
      tick();
      left--;
    end while (en_fall_cnt == falls0 && left > 0);
    chki("t4_en_fell", en_fall_cnt - falls0, 1);
    chki("t4_en_high_cycles", last_en_run, TO);
    chki("t4_timeout_err", int'(timeout_err), 1);
    chki("t4_no_ack", ack_cnt, acks0);
    fin_never = 1'b0;
    run_until_idle("t4_done", 300);
    chki("t4_err_sticky", int'(timeout_err), 1);
    chki("t4_regrant_ack", ack_cnt - acks0, 1);
    chki("t4_sb_empty", sb.size(), 0);

    // RST in WAIT_FIN aborts the frame; the pending request is granted again
    push(1, f1);
    pend[1] = 1;
    acks0 = ack_cnt;
    left = 50;
    drive_req();
    do begin
      tick();
      left--;
    end while (en_run < 3 && left > 0);
    chki("t5_in_wait_fin", int'(oled_en), 1);
    RST = 1'b1;
    tick();
    reset_checks("t5_rst");
    gap_valid = 0;
    RST = 1'b0;
    run_until_idle("t5_done", 300);
    chki("t5_single_ack", ack_cnt - acks0, 1);
    chki("t5_err_clear", int'(timeout_err), 0);
    chki("t5_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_display_arbiter.md
Name: oled_display_arbiter

Overview:
- Shares the single PmodOLED controller (EN/FIN handshake, four 128-bit page buses) among NUM_REQ independent display requesters, e.g. price screen, status screen and error screen.
- Arbitrates round-robin and latches the winner's page data.
- Drives the controller's EN through a full EN-high / FIN-high / EN-low / FIN-low cycle.
- Enforces a minimum on-screen hold time before the next grant.
- Sits between the vending-machine application logic and the OLED controller.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 50000000, minimum CLK cycles a finished frame stays on screen before another grant (1 s at 50 MHz). Must be at least 1.
- TIMEOUT_CYCLES, 100000000, maximum cycles waiting for FIN to rise or fall before error.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester level request; held until its ack.
- req_pages  in  NUM_REQ*512  requester i occupies bits [i*512 +: 512], ordered Page0 (LSBs) .. Page3.
- ack  out  NUM_REQ  one-cycle pulse to the granted requester when its frame is fully drawn.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- oled_en  out  1  EN to the OLED controller.
- oled_page0..oled_page3  out  128 each  page buses to the OLED controller.
- oled_fin  in  1  FIN from the OLED controller.
- timeout_err  out  1  sticky flag, set on handshake timeout, cleared only by RST.

Behaviour:
- Reset values: oled_en=0, ack=0, busy=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), oled_page0..3=0, timeout_err=0, state=IDLE, counters=0.
- Output timing: all outputs are registered. Page buses change only in the GRANT state and stay stable while oled_en=1.

States:
- IDLE
  - If any req bit is set, pick the first set bit scanning from (grant_id+1) mod NUM_REQ upward with wrap.
  - Register it into grant_id and go to GRANT.
  - With no requests, stay in IDLE.
- GRANT (1 cycle)
  - Latch the req_pages slice for grant_id onto oled_page0..3.
  - Set oled_en=1, clear the timer, go to WAIT_FIN.
- WAIT_FIN
  - Hold oled_en=1.
  - When oled_fin=1: pulse ack[grant_id] for 1 cycle, set oled_en=0, clear the timer, go to WAIT_REL.
  - If the timer reaches TIMEOUT_CYCLES first: set timeout_err, set oled_en=0, go to WAIT_REL. No ack is issued; the request stays pending.
- WAIT_REL
  - oled_en=0.
  - When oled_fin=0: clear the timer, go to HOLD.
  - If the timer reaches TIMEOUT_CYCLES: set timeout_err, go to HOLD.
- HOLD
  - Count HOLD_CYCLES cycles, then go to IDLE.
  - New requests are ignored while in HOLD.

Handshake and edge rules:
- Latency: a request arriving in IDLE gives oled_en=1 two cycles later (IDLE decision, then GRANT).
- The requester must drop req within 1 cycle of ack. If req is still high in IDLE, it is treated as a new request and gets a new grant.
- A req deasserted after grant but before ack is ignored: the frame completes and the ack is still pulsed.
- Simultaneous requests are served round-robin; no requester is served twice while another is pending.
- RST asserted in any state returns to the reset values on the next edge and aborts the frame; the controller is reset by the same RST.
- Timer width is clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)+1). The timer saturates and never wraps.

Decomposition:
- Shared package oled_pkg holds:
  - state encoding: IDLE, GRANT, WAIT_FIN, WAIT_REL, HOLD;
  - PAGE_W=128 and PAGES=4;
  - the function clog2.
- One sub-module, rr_arbiter: combinational round-robin pick with inputs req and last_id and outputs valid and id. It is reusable for other shared peripherals.

Test Plan:
Bench settings: NUM_REQ=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=20. Behavioural OLED model raises FIN 10 cycles after EN rises and drops FIN 1 cycle after EN falls.
1. Single request, req=3'b010, pages = distinct patterns -> oled_en rises 2 cycles later; oled_page0..3 equal requester 1's slice; ack=3'b010 for exactly 1 cycle when FIN rises; busy returns to 0 after WAIT_REL plus 4 HOLD cycles.
2. All requests at once, req=3'b111 held until each ack -> grant order 0, 1, 2; three ack pulses in that order; each frame separated by at least 4 idle-bus cycles.
3. Fairness: requester 0 re-requests immediately after every ack while requester 2 holds req -> grants alternate 0, 2, 0, 2.
4. Model never raises FIN -> oled_en drops 20 cycles after GRANT; timeout_err=1 and stays 1; no ack; the request is re-granted after HOLD.
5. RST pulsed mid-WAIT_FIN -> next cycle oled_en=0, busy=0, grant_id=2, pages=0, timeout_err=0; the pending request is granted again after RST is released.
6. Requester changes req_pages while oled_en=1 -> oled_page buses stay unchanged until the next GRANT.
